// File: rtl/divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package divider_pkg;

  // Default widths pair with the 12x9 multiplier: its 21-bit product divided by a 9-bit operand.
  localparam int DVDND_BITS_DEF = 21;
  localparam int DVSR_BITS_DEF  = 9;

  // Controller states: waiting for operands, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// then subtract the divisor if it fits.
module div_step #(
  parameter int DVSR_BITS = 9
) (
  input  logic [DVSR_BITS:0]   r_i,
  input  logic                 bit_i,
  input  logic [DVSR_BITS-1:0] divisor_i,
  output logic [DVSR_BITS:0]   r_o,
  output logic                 q_o
);

  logic [DVSR_BITS:0] trial;
  logic [DVSR_BITS:0] dvsrExt;

  // The shift drops the top bit of r, which is always 0 because r stays below the divisor.
  always_comb begin
    trial   = (r_i << 1) | {{DVSR_BITS{1'b0}}, bit_i};
    dvsrExt = {1'b0, divisor_i};
    if (trial >= dvsrExt) begin
      r_o = trial - dvsrExt;
      q_o = 1'b1;
    end else begin
      r_o = trial;
      q_o = 1'b0;
    end
  end

endmodule

// File: rtl/divider_seq_top.sv
// Sequential radix-2 restoring unsigned divider.
// Produces one quotient bit per clock, with valid/ready handshakes on both sides.
module divider_seq_top
  import divider_pkg::*;
#(
  parameter int DVDND_BITS = DVDND_BITS_DEF,
  parameter int DVSR_BITS  = DVSR_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DVDND_BITS-1:0] dividend,
  input  logic [DVSR_BITS-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DVDND_BITS-1:0] quotient,
  output logic [DVSR_BITS-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DVDND_BITS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DVDND_BITS - 1);

  state_e                state_q, state_d;
  logic [DVDND_BITS-1:0] dvdq_q, dvdq_d;
  logic [DVSR_BITS-1:0]  dvsr_q, dvsr_d;
  logic [DVSR_BITS:0]    r_q, r_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DVDND_BITS-1:0] quotient_q, quotient_d;
  logic [DVSR_BITS-1:0]  remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  logic [DVSR_BITS:0]    rNext;
  logic                  qBit;

  div_step #(
    .DVSR_BITS(DVSR_BITS)
  ) u_step (
    .r_i      (r_q),
    .bit_i    (dvdq_q[DVDND_BITS-1]),
    .divisor_i(dvsr_q),
    .r_o      (rNext),
    .q_o      (qBit)
  );

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvdq_q      <= '0;
      dvsr_q      <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvdq_q      <= dvdq_d;
      dvsr_q      <= dvsr_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Next-state logic: dividend bits shift out of dvdq as quotient bits shift in behind them.
  always_comb begin
    state_d     = state_q;
    dvdq_d      = dvdq_q;
    dvsr_d      = dvsr_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvdq_d = dividend;
          dvsr_d = divisor;
          r_d    = '0;
          cnt_d  = CNT_LOAD;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d    = rNext;
        dvdq_d = {dvdq_q[DVDND_BITS-2:0], qBit};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d     = DONE;
          quotient_d  = {dvdq_q[DVDND_BITS-2:0], qBit};
          remainder_d = rNext[DVSR_BITS-1:0];
          dbz_d       = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq_top.sv
// Self-checking bench for divider_seq_top: directed vector table, hand-written
// backpressure and reset-abort sequences, then randomized operands against an
// arithmetic reference model.
module tb_divider_seq_top;

  localparam int NDVD = 21;
  localparam int NDVS = 9;
  localparam int NRAND = 2000;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [NDVD-1:0] dividend;
  logic [NDVS-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [NDVD-1:0] quotient;
  logic [NDVS-1:0] remainder;
  logic            div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NDVD-1:0] dvd;
    logic [NDVS-1:0] dvs;
    logic [NDVD-1:0] q;
    logic [NDVS-1:0] r;
    logic            dbz;
    int              lat;
  } vec_t;

  vec_t vecs[10];

  divider_seq_top #(
    .DVDND_BITS(NDVD),
    .DVSR_BITS (NDVS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer division; divide-by-zero saturates the quotient.
  task automatic refModel(input logic [NDVD-1:0] dvd, input logic [NDVS-1:0] dvs,
                          output logic [NDVD-1:0] q, output logic [NDVS-1:0] r,
                          output logic dbz);
    longint a;
    longint b;
    a = longint'(dvd);
    b = longint'(dvs);
    if (b == 0) begin
      q   = NDVD'((64'd1 << NDVD) - 1);
      r   = '0;
      dbz = 1'b1;
    end else begin
      q   = NDVD'(a / b);
      r   = NDVS'(a % b);
      dbz = 1'b0;
    end
  endtask

  // One full transaction: accept, latency measurement, result checks, optional stall, handshake.
  task automatic applyStimulus(input logic [NDVD-1:0] dvd, input logic [NDVS-1:0] dvs,
                               input logic [NDVD-1:0] expQ, input logic [NDVS-1:0] expR,
                               input logic expDbz, input int expLat, input int stall,
                               input string tag);
    int lat;
    @(negedge clk);
    checkOutput({tag, ".in_ready_idle"}, longint'(in_ready), 1);
    in_valid  = 1'b1;
    dividend  = dvd;
    divisor   = dvs;
    out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = NDVD'($urandom);
    divisor  = NDVS'($urandom);
    checkOutput({tag, ".in_ready_busy"}, longint'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ".latency"}, longint'(lat), longint'(expLat));
    checkOutput({tag, ".quotient"}, longint'(quotient), longint'(expQ));
    checkOutput({tag, ".remainder"}, longint'(remainder), longint'(expR));
    checkOutput({tag, ".div_by_zero"}, longint'(div_by_zero), longint'(expDbz));
    if (dvs != 0) begin
      checkOutput({tag, ".invariant"},
                  longint'(quotient) * longint'(dvs) + longint'(remainder), longint'(dvd));
      checkOutput({tag, ".rem_lt_dvs"}, longint'(remainder < dvs), 1);
    end
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      checkOutput({tag, ".stall_valid"}, longint'(out_valid), 1);
      checkOutput({tag, ".stall_quotient"}, longint'(quotient), longint'(expQ));
      out_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput({tag, ".valid_dropped"}, longint'(out_valid), 0);
    checkOutput({tag, ".in_ready_back"}, longint'(in_ready), 1);
    checkOutput({tag, ".quotient_held"}, longint'(quotient), longint'(expQ));
  endtask

  // Main test sequence.
  initial begin
    logic [NDVD-1:0] rq;
    logic [NDVS-1:0] rr;
    logic            rdbz;
    logic [NDVD-1:0] dvd;
    logic [NDVS-1:0] dvs;
    int              lat;

    vecs[0] = '{dvd: 21'd100,     dvs: 9'd7,   q: 21'd14,      r: 9'd2, dbz: 1'b0, lat: 21};
    vecs[1] = '{dvd: 21'd2097151, dvs: 9'd511, q: 21'd4104,    r: 9'd7, dbz: 1'b0, lat: 21};
    vecs[2] = '{dvd: 21'd5,       dvs: 9'd9,   q: 21'd0,       r: 9'd5, dbz: 1'b0, lat: 21};
    vecs[3] = '{dvd: 21'd1234,    dvs: 9'd0,   q: 21'h1FFFFF,  r: 9'd0, dbz: 1'b1, lat: 0};
    vecs[4] = '{dvd: 21'd0,       dvs: 9'd1,   q: 21'd0,       r: 9'd0, dbz: 1'b0, lat: 21};
    vecs[5] = '{dvd: 21'd2097151, dvs: 9'd1,   q: 21'd2097151, r: 9'd0, dbz: 1'b0, lat: 21};
    vecs[6] = '{dvd: 21'd1000,    dvs: 9'd3,   q: 21'd333,     r: 9'd1, dbz: 1'b0, lat: 21};
    vecs[7] = '{dvd: 21'd511,     dvs: 9'd511, q: 21'd1,       r: 9'd0, dbz: 1'b0, lat: 21};
    vecs[8] = '{dvd: 21'd2097150, dvs: 9'd2,   q: 21'd1048575, r: 9'd0, dbz: 1'b0, lat: 21};
    vecs[9] = '{dvd: 21'd510,     dvs: 9'd511, q: 21'd0,       r: 9'd510, dbz: 1'b0, lat: 21};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    checkOutput("reset.in_ready", longint'(in_ready), 1);
    checkOutput("reset.out_valid", longint'(out_valid), 0);
    checkOutput("reset.quotient", longint'(quotient), 0);
    checkOutput("reset.remainder", longint'(remainder), 0);
    checkOutput("reset.div_by_zero", longint'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dbz,
                    vecs[i].lat, (i % 3 == 2) ? 2 : 0, $sformatf("vec%0d", i));
    end

    // Backpressure: result must stay frozen and new operands must be ignored.
    @(negedge clk);
    in_valid  = 1'b1;
    dividend  = 21'd12345;
    divisor   = 9'd67;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("bp.latency", longint'(lat), 21);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      dividend = 21'd999;
      divisor  = 9'd0;
      @(negedge clk);
      checkOutput("bp.out_valid", longint'(out_valid), 1);
      checkOutput("bp.in_ready", longint'(in_ready), 0);
      checkOutput("bp.quotient", longint'(quotient), 184);
      checkOutput("bp.remainder", longint'(remainder), 17);
      checkOutput("bp.div_by_zero", longint'(div_by_zero), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp.released_valid", longint'(out_valid), 0);
    checkOutput("bp.released_ready", longint'(in_ready), 1);
    checkOutput("bp.quotient_held", longint'(quotient), 184);

    // Reset abort in the middle of 1000/3.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 21'd1000;
    divisor  = 9'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort.in_ready", longint'(in_ready), 1);
    checkOutput("abort.out_valid", longint'(out_valid), 0);
    checkOutput("abort.quotient", longint'(quotient), 0);
    checkOutput("abort.remainder", longint'(remainder), 0);
    checkOutput("abort.div_by_zero", longint'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(21'd1000, 9'd3, 21'd333, 9'd1, 1'b0, 21, 0, "abort.rerun");

    // Randomized operands with occasional output stalls.
    for (int n = 0; n < NRAND; n++) begin
      dvd = NDVD'($urandom) >> $urandom_range(0, 20);
      if ($urandom_range(0, 15) == 0) dvd = '0;
      case ($urandom_range(0, 15))
        0:       dvs = '0;
        1:       dvs = 9'd1;
        default: dvs = NDVS'($urandom) >> $urandom_range(0, 8);
      endcase
      refModel(dvd, dvs, rq, rr, rdbz);
      applyStimulus(dvd, dvs, rq, rr, rdbz, (dvs == 0) ? 0 : 21,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
